// File: rtl/jesd204_fec_encode_mlane_if.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_fec_encode_mlane_if
// Purpose  : Bus bundle for the multi-lane JESD204C FEC parity generator.
// Revision : 1.0 - initial release
// ============================================================================
interface jesd204_fec_encode_mlane_if #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int FEC_WIDTH  = 26
);
    logic                            enable;
    logic [NUM_LANES-1:0]            lane_mask;
    logic                            in_valid;
    logic                            in_eomb;
    logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
    logic [NUM_LANES*FEC_WIDTH-1:0]  fec_out;
    logic                            fec_valid;
    logic [15:0]                     mb_count;
    logic                            align_error;
    logic                            align_error_clr;

    // Source side: scrambler / link control
    modport master (
        output enable, lane_mask, in_valid, in_eomb, in_data, align_error_clr,
        input  fec_out, fec_valid, mb_count, align_error
    );

    // Encoder side
    modport slave (
        input  enable, lane_mask, in_valid, in_eomb, in_data, align_error_clr,
        output fec_out, fec_valid, mb_count, align_error
    );
endinterface
`default_nettype wire

// File: rtl/jesd204_fec_encode_mlane.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_fec_encode_mlane
// Purpose  : Per-lane 26-bit shortened-cyclic-code parity over 2048-bit
//            multiblocks, with eomb alignment checking and lane masking.
// Revision : 1.0 - initial release
// ============================================================================
module jesd204_fec_encode_mlane #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int FEC_WIDTH  = 26
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    jesd204_fec_encode_mlane_if.slave bus
);
    localparam int c_BEATS = 2048 / DATA_WIDTH;
    localparam int c_CNT_W = $clog2(c_BEATS);
    localparam int c_RW    = NUM_LANES * FEC_WIDTH;
    // g(x) = x^26 + x^21 + x^17 + x^9 + x^4 + 1, leading term implicit
    localparam logic [FEC_WIDTH-1:0] c_POLY = FEC_WIDTH'(26'h0220211);
    localparam logic [c_CNT_W-1:0]   c_LAST = c_CNT_W'(c_BEATS - 1);

    // Serial LFSR unrolled over one beat; data bit 0 enters first.
    function automatic logic [FEC_WIDTH-1:0] f_advance(
        input logic [FEC_WIDTH-1:0]  rem,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [FEC_WIDTH-1:0] r;
        logic                 fb;
        r = rem;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb = r[FEC_WIDTH-1] ^ data[i];
            r  = {r[FEC_WIDTH-2:0], 1'b0} ^ (fb ? c_POLY : '0);
        end
        return r;
    endfunction

    logic [c_RW-1:0]    r_rem;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [c_RW-1:0]    r_fec_out;
    logic               r_fec_valid;
    logic [15:0]        r_mb_count;
    logic               r_align_error;

    logic [c_RW-1:0]    w_next_rem;
    logic [c_RW-1:0]    w_lane_keep;
    logic               w_beat;
    logic               w_last;
    logic               w_done;
    logic               w_misalign;

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign w_next_rem[l*FEC_WIDTH +: FEC_WIDTH] = bus.lane_mask[l]
                ? f_advance(r_rem[l*FEC_WIDTH +: FEC_WIDTH],
                            bus.in_data[l*DATA_WIDTH +: DATA_WIDTH])
                : '0;
            assign w_lane_keep[l*FEC_WIDTH +: FEC_WIDTH] = {FEC_WIDTH{bus.lane_mask[l]}};
        end
    endgenerate

    assign w_beat     = bus.enable & bus.in_valid;
    assign w_last     = (r_beat_cnt == c_LAST);
    assign w_done     = w_beat & bus.in_eomb & w_last;
    // Early eomb and missing eomb are both an eomb/last-beat disagreement
    assign w_misalign = w_beat & (bus.in_eomb ^ w_last);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem         <= '0;
            r_beat_cnt    <= '0;
            r_fec_out     <= '0;
            r_fec_valid   <= 1'b0;
            r_mb_count    <= '0;
            r_align_error <= 1'b0;
        end else if (!bus.enable) begin
            r_rem         <= '0;
            r_beat_cnt    <= '0;
            r_fec_out     <= '0;
            r_fec_valid   <= 1'b0;
            r_mb_count    <= '0;
            r_align_error <= 1'b0;
        end else begin
            r_fec_valid <= w_done;
            if (w_done) begin
                r_fec_out  <= w_next_rem;
                r_mb_count <= r_mb_count + 16'd1;
            end
            if (w_beat) begin
                if (w_done || w_misalign) begin
                    r_rem      <= '0;
                    r_beat_cnt <= '0;
                end else begin
                    r_rem      <= w_next_rem;
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
            // A new misalignment outranks a simultaneous clear
            if (w_misalign) begin
                r_align_error <= 1'b1;
            end else if (bus.align_error_clr) begin
                r_align_error <= 1'b0;
            end
        end
    end

    assign bus.fec_out     = r_fec_out & w_lane_keep;
    assign bus.fec_valid   = r_fec_valid;
    assign bus.mb_count    = r_mb_count;
    assign bus.align_error = r_align_error;

endmodule
`default_nettype wire

// File: tb/tb_jesd204_fec_encode_mlane.sv
`default_nettype none
// ============================================================================
// Module   : tb_jesd204_fec_encode_mlane
// Purpose  : Self-checking bench with a polynomial-arithmetic parity model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jesd204_fec_encode_mlane;
    localparam int NL    = 4;
    localparam int DW    = 64;
    localparam int BEATS = 2048 / DW;
    localparam int FW    = 26;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    bit   cmp_en = 1'b0;
    int   good_mb = 0;

    always #5 clk = ~clk;

    jesd204_fec_encode_mlane_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .FEC_WIDTH(FW)) bus ();
    jesd204_fec_encode_mlane_if #(.NUM_LANES(1),  .DATA_WIDTH(32), .FEC_WIDTH(FW)) bus32 ();

    jesd204_fec_encode_mlane #(.NUM_LANES(NL), .DATA_WIDTH(DW), .FEC_WIDTH(FW)) u_dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );
    jesd204_fec_encode_mlane #(.NUM_LANES(1), .DATA_WIDTH(32), .FEC_WIDTH(FW)) u_dut32 (
        .clk(clk), .resetn(resetn), .bus(bus32)
    );

    // x^k mod g(x) for every degree a shifted 2048-bit message can reach
    logic [FW-1:0]    pow_tab [0:2073];
    logic [DW-1:0]    m_beats [NL][BEATS];
    logic [NL*FW-1:0] exp_fec   = '0;
    logic             exp_valid = 1'b0;
    logic [15:0]      exp_mb    = '0;
    logic             exp_align = 1'b0;
    int               m_cnt     = 0;
    logic [NL*DW-1:0] mb_data [BEATS];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] model_parity(input int lane);
        logic [FW-1:0] p;
        p = '0;
        for (int b = 0; b < BEATS; b++)
            for (int i = 0; i < DW; i++)
                if (m_beats[lane][b][i]) p ^= pow_tab[2073 - (b*DW + i)];
        return p;
    endfunction

    // Behavioural model: expected registered outputs from beat history
    always @(posedge clk or negedge resetn) begin
        bit set_err;
        set_err = 1'b0;
        if (!resetn || !bus.enable) begin
            exp_fec = '0; exp_valid = 1'b0; exp_mb = '0; exp_align = 1'b0; m_cnt = 0;
        end else begin
            exp_valid = 1'b0;
            if (bus.in_valid) begin
                for (int l = 0; l < NL; l++)
                    m_beats[l][m_cnt] = bus.lane_mask[l] ? bus.in_data[l*DW +: DW] : '0;
                if (bus.in_eomb && m_cnt == BEATS-1) begin
                    for (int l = 0; l < NL; l++)
                        exp_fec[l*FW +: FW] = bus.lane_mask[l] ? model_parity(l) : '0;
                    exp_valid = 1'b1;
                    exp_mb    = exp_mb + 16'd1;
                    m_cnt     = 0;
                end else if (bus.in_eomb || m_cnt == BEATS-1) begin
                    set_err = 1'b1;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (set_err) exp_align = 1'b1;
            else if (bus.align_error_clr) exp_align = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [NL*FW-1:0] keep;
        #1;
        if (cmp_en) begin
            for (int l = 0; l < NL; l++) keep[l*FW +: FW] = {FW{bus.lane_mask[l]}};
            check("cmp_fec_valid",   bus.fec_valid,   exp_valid);
            check("cmp_fec_out",     bus.fec_out,     exp_fec & keep);
            check("cmp_mb_count",    bus.mb_count,    exp_mb);
            check("cmp_align_error", bus.align_error, exp_align);
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_eomb  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_partial(input int n, input bit eomb_last, input bit gaps);
        for (int b = 0; b < n; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            bus.in_valid = 1'b1;
            bus.in_data  = mb_data[b];
            bus.in_eomb  = eomb_last && (b == n-1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_eomb  = 1'b0;
    endtask

    task automatic send_mb(input bit gaps);
        send_partial(BEATS, 1'b1, gaps);
        good_mb++;
        check("mb_pulse", bus.fec_valid, 1'b1);
    endtask

    task automatic clear_data();
        for (int b = 0; b < BEATS; b++) mb_data[b] = '0;
    endtask

    task automatic fill_random();
        for (int b = 0; b < BEATS; b++)
            for (int w = 0; w < NL*DW/32; w++) mb_data[b][w*32 +: 32] = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fec_out"},   bus.fec_out,     '0);
        check({tag, "_fec_valid"}, bus.fec_valid,   1'b0);
        check({tag, "_mb_count"},  bus.mb_count,    16'd0);
        check({tag, "_align"},     bus.align_error, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NL*FW-1:0] e;
        pow_tab[0] = 26'd1;
        for (int k = 1; k <= 2073; k++)
            pow_tab[k] = {pow_tab[k-1][FW-2:0], 1'b0} ^ (pow_tab[k-1][FW-1] ? 26'h0220211 : 26'h0);
        check("model_x26", pow_tab[26], 26'h0220211);
        check("model_x27", pow_tab[27], 26'h0440422);

        bus.enable = 1'b0; bus.lane_mask = '1; bus.in_valid = 1'b0; bus.in_eomb = 1'b0;
        bus.in_data = '0; bus.align_error_clr = 1'b0;
        bus32.enable = 1'b0; bus32.lane_mask = 1'b1; bus32.in_valid = 1'b0; bus32.in_eomb = 1'b0;
        bus32.in_data = '0; bus32.align_error_clr = 1'b0;
        #1 resetn = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);

        // Three all-zero multiblocks
        clear_data();
        for (int k = 0; k < 3; k++) begin
            send_mb(1'b0);
            check("zero_fec", bus.fec_out, '0);
        end
        idle(2);
        check("zero_mb_count", bus.mb_count, 16'd3);

        // Lane 0 last bit -> x^26 mod g
        clear_data();
        mb_data[BEATS-1][DW-1] = 1'b1;
        send_mb(1'b0);
        check("lane0_last_bit", bus.fec_out, 104'h0220211);

        // Lane 1 first bit -> x^2073 mod g
        clear_data();
        mb_data[0][DW] = 1'b1;
        send_mb(1'b0);
        e = '0; e[2*FW-1:FW] = pow_tab[2073];
        check("lane1_first_bit", bus.fec_out, e);

        // Linearity: both bits together
        mb_data[BEATS-1][2*DW-1] = 1'b1;
        send_mb(1'b0);
        e = '0; e[2*FW-1:FW] = pow_tab[2073] ^ 26'h0220211;
        check("lane1_linearity", bus.fec_out, e);

        // Random data with gaps
        for (int k = 0; k < 2; k++) begin
            fill_random();
            send_mb(1'b1);
        end
        idle(3);

        // Early eomb at beat 10
        fill_random();
        send_partial(11, 1'b1, 1'b0);
        check("early_align", bus.align_error, 1'b1);
        check("early_no_valid", bus.fec_valid, 1'b0);
        check("early_mb_count", bus.mb_count, 16'(good_mb));
        fill_random();
        send_mb(1'b1);
        check("sticky_align", bus.align_error, 1'b1);

        // Clear coinciding with a new misalignment: set wins
        bus.align_error_clr = 1'b1;
        send_partial(1, 1'b1, 1'b0);
        bus.align_error_clr = 1'b0;
        check("clr_vs_set", bus.align_error, 1'b1);
        bus.align_error_clr = 1'b1;
        @(negedge clk);
        bus.align_error_clr = 1'b0;
        check("clr_alone", bus.align_error, 1'b0);

        // Missing eomb on the last beat
        fill_random();
        send_partial(BEATS, 1'b0, 1'b0);
        check("missing_eomb_align", bus.align_error, 1'b1);
        check("missing_eomb_no_valid", bus.fec_valid, 1'b0);
        bus.align_error_clr = 1'b1;
        @(negedge clk);
        bus.align_error_clr = 1'b0;

        // Lane mask 1010
        bus.lane_mask = 4'b1010;
        fill_random();
        send_mb(1'b1);
        check("mask_lane0_zero", bus.fec_out[FW-1:0], '0);
        check("mask_lane2_zero", bus.fec_out[3*FW-1:2*FW], '0);
        idle(2);
        bus.lane_mask = 4'b1111;

        // Asynchronous reset at beat 15
        fill_random();
        send_partial(15, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        fill_random();
        send_mb(1'b1);
        check("post_reset_mb_count", bus.mb_count, 16'd1);

        // Enable low clears everything
        bus.enable = 1'b0;
        @(negedge clk);
        check_all_zero("enable_low");
        bus.enable = 1'b1;
        @(negedge clk);

        // 32-bit datapath: last bit of beat 63
        bus32.enable = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 64; b++) begin
            bus32.in_valid = 1'b1;
            bus32.in_data  = (b == 63) ? 32'h8000_0000 : 32'h0;
            bus32.in_eomb  = (b == 63);
            @(negedge clk);
        end
        bus32.in_valid = 1'b0;
        bus32.in_eomb  = 1'b0;
        check("dw32_valid", bus32.fec_valid, 1'b1);
        check("dw32_fec", bus32.fec_out, 26'h0220211);
        check("dw32_mb_count", bus32.mb_count, 16'd1);
        idle(2);

        cmp_en = 1'b0;
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
